// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for an ECP5 EHXPLLL: drives PLL RST, filters a resynchronised LOCK,
// retries on timeout, and releases downstream resets in staggered order.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned NUM_RESETS          = 2,
  parameter int unsigned RELEASE_GAP         = 8,
  localparam int unsigned RetryW             = $clog2(MAX_RETRIES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock_i,
  input  logic                  clear_fault,
  output logic                  pll_rst_o,
  output logic                  locked_o,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  fault_o,
  output logic [RetryW-1:0]     retry_count,
  output logic [7:0]            lock_loss_count
);

  localparam int unsigned PulseW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned FiltW  = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int unsigned RelW   = $clog2((NUM_RESETS - 1) * RELEASE_GAP + 2);

  localparam logic [PulseW-1:0]     PulseLast  = PulseW'(RST_PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0]     TimerLast  = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [FiltW-1:0]      FiltLast   = FiltW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [RelW-1:0]       RelLast    = RelW'((NUM_RESETS - 1) * RELEASE_GAP);
  localparam logic [RetryW-1:0]     RetryFinal = RetryW'(MAX_RETRIES - 1);
  localparam logic [NUM_RESETS-1:0] RstEntry   = {NUM_RESETS{1'b1}} << 1;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StFilter,
    StRelease,
    StRun,
    StFault
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [PulseW-1:0]      pulse_q;
  logic [TimerW-1:0]      timer_q;
  logic [FiltW-1:0]       filt_q;
  logic [RelW-1:0]        rel_q;
  logic                   lock_s;
  logic [RelW-1:0]        rel_inc;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign rel_inc = rel_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StResetPll;
      sync_q          <= '0;
      pulse_q         <= '0;
      timer_q         <= '0;
      filt_q          <= '0;
      rel_q           <= '0;
      pll_rst_o       <= 1'b1;
      locked_o        <= 1'b0;
      rst_out         <= '1;
      fault_o         <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      unique case (state_q)
        StResetPll: begin
          if (pulse_q == PulseLast) begin
            state_q   <= StWaitLock;
            pll_rst_o <= 1'b0;
            pulse_q   <= '0;
            timer_q   <= '0;
          end else begin
            pulse_q <= pulse_q + 1'b1;
          end
        end
        StWaitLock: begin
          // Lock takes priority over a timeout landing on the same cycle.
          if (lock_s) begin
            state_q <= StFilter;
            filt_q  <= FiltW'(1);
          end else if (timer_q >= TimerLast) begin
            retry_count <= retry_count + 1'b1;
            pll_rst_o   <= 1'b1;
            pulse_q     <= '0;
            if (retry_count == RetryFinal) begin
              state_q <= StFault;
              fault_o <= 1'b1;
            end else begin
              state_q <= StResetPll;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StFilter: begin
          // Filter time keeps charging the lock timeout.
          if (timer_q < TimerLast) timer_q <= timer_q + 1'b1;
          if (!lock_s) begin
            state_q <= StWaitLock;
          end else if (filt_q >= FiltLast) begin
            state_q     <= (NUM_RESETS == 1) ? StRun : StRelease;
            locked_o    <= 1'b1;
            retry_count <= '0;
            rst_out     <= RstEntry;
            rel_q       <= '0;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end
        StRelease, StRun: begin
          // Loss of lock is not filtered and beats any pending release step.
          if (!lock_s) begin
            state_q   <= StResetPll;
            pll_rst_o <= 1'b1;
            locked_o  <= 1'b0;
            rst_out   <= '1;
            pulse_q   <= '0;
            if (lock_loss_count != 8'hff) lock_loss_count <= lock_loss_count + 1'b1;
          end else if (state_q == StRelease) begin
            rel_q <= rel_inc;
            for (int i = 1; i < NUM_RESETS; i++) begin
              if (rel_inc >= RelW'(i * RELEASE_GAP)) rst_out[i] <= 1'b0;
            end
            if (rel_inc >= RelLast) state_q <= StRun;
          end
        end
        StFault: begin
          if (clear_fault) begin
            state_q     <= StResetPll;
            fault_o     <= 1'b0;
            retry_count <= '0;
            pulse_q     <= '0;
          end
        end
        default: state_q <= StResetPll;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: expected output snapshots are queued by the stimulus and
// popped by a monitor whenever the registered outputs change.
module tb_pll_lock_supervisor;

  localparam int unsigned SyncStages = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pll_lock_i = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst_o;
  logic       locked_o;
  logic [2:0] rst_out;
  logic       fault_o;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int errs = 0;
  int chks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_prev;
  logic [15:0] mon_cur;
  logic [15:0] mon_exp;
  bit          mon_first = 1'b1;
  int          n;

  pll_lock_supervisor #(
    .SYNC_STAGES        (SyncStages),
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_FILTER_CYCLES (8),
    .MAX_RETRIES        (3),
    .NUM_RESETS         (3),
    .RELEASE_GAP        (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pll_lock_i     (pll_lock_i),
    .clear_fault    (clear_fault),
    .pll_rst_o      (pll_rst_o),
    .locked_o       (locked_o),
    .rst_out        (rst_out),
    .fault_o        (fault_o),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] snap(input logic p, input logic l, input logic [2:0] r,
                                       input logic f, input logic [1:0] rc,
                                       input logic [7:0] c);
    return {p, l, r, f, rc, c};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Queue a full release sequence with the given loss count.
  task automatic push_release(input logic [7:0] c);
    exp_q.push_back(snap(1'b0, 1'b1, 3'b110, 1'b0, 2'd0, c));
    exp_q.push_back(snap(1'b0, 1'b1, 3'b100, 1'b0, 2'd0, c));
    exp_q.push_back(snap(1'b0, 1'b1, 3'b000, 1'b0, 2'd0, c));
  endtask

  // Count negedges until a condition holds; an expired budget is a failed check.
  task automatic wait_until(input int which, input int budget, input string name,
                            output int cycles);
    bit hit;
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < budget) begin
      @(negedge clock);
      cycles++;
      case (which)
        0: hit = (pll_rst_o === 1'b0);
        1: hit = (locked_o === 1'b1);
        2: hit = (rst_out === 3'b000);
        3: hit = (fault_o === 1'b1);
        4: hit = (locked_o === 1'b0);
        default: hit = (rst_out === 3'b110);
      endcase
    end
    if (!hit) begin
      chks++;
      errs++;
      $display("FAIL timeout_%s waited=%0d cycles, condition never met", name, cycles);
    end
  endtask

  // Monitor: every change of the output vector must match the next queued snapshot.
  initial begin
    forever begin
      @(negedge clock);
      mon_cur = {pll_rst_o, locked_o, rst_out, fault_o, retry_count, lock_loss_count};
      if (mon_first || mon_cur !== mon_prev) begin
        mon_first = 1'b0;
        chks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL sb_unexpected got=%h expected=no change", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            errs++;
            $display("FAIL sb_seq got=%h expected=%h", mon_cur, mon_exp);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean bring-up
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    push_release(8'd0);
    reset = 1'b0;
    wait_until(0, 50, "rst_fall", n);
    check("rst_pulse_len", n, 4);
    @(negedge clock);
    pll_lock_i = 1'b1;
    wait_until(1, 50, "lock1", n);
    check("lock_latency", n, 10);
    wait_until(2, 50, "run1", n);
    check("release_span", n, 4);
    check("retry_after_lock", int'(retry_count), 0);

    // Glitchy lock
    @(negedge clock);
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    reset = 1'b1;
    pll_lock_i = 1'b0;
    repeat (2) @(negedge clock);
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    push_release(8'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    pll_lock_i = 1'b1;
    repeat (5) @(negedge clock);
    pll_lock_i = 1'b0;
    @(negedge clock);
    pll_lock_i = 1'b1;
    wait_until(1, 50, "lock2", n);
    check("glitch_lock_latency", n, 10);
    check("glitch_retry", int'(retry_count), 0);
    wait_until(2, 50, "run2", n);

    // Timeout to fault, then clear
    @(negedge clock);
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    reset = 1'b1;
    pll_lock_i = 1'b0;
    repeat (2) @(negedge clock);
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd1, 8'd0));
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd1, 8'd0));
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd2, 8'd0));
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd2, 8'd0));
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 8'd0));
    reset = 1'b0;
    wait_until(3, 300, "fault", n);
    check("fault_retry", int'(retry_count), 3);
    check("fault_pll_rst", int'(pll_rst_o), 1);
    repeat (5) @(negedge clock);
    check("fault_sticky", int'(fault_o), 1);
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    push_release(8'd0);
    clear_fault = 1'b1;
    @(negedge clock);
    clear_fault = 1'b0;
    check("clear_fault_o", int'(fault_o), 0);
    check("clear_retry", int'(retry_count), 0);
    check("clear_pll_rst", int'(pll_rst_o), 1);
    pll_lock_i = 1'b1;
    wait_until(2, 80, "run3", n);

    // Loss of lock in RUN
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd1));
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd1));
    push_release(8'd1);
    pll_lock_i = 1'b0;
    @(negedge clock);
    pll_lock_i = 1'b1;
    wait_until(4, 20, "loss", n);
    check("loss_latency", n + 1, SyncStages + 1);
    check("loss_rst_out", int'(rst_out), 7);
    check("loss_count1", int'(lock_loss_count), 1);
    wait_until(2, 80, "run4", n);

    // Saturation of the loss counter
    for (int k = 2; k <= 260; k++) begin
      exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, (k > 255) ? 8'd255 : 8'(k)));
      exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, (k > 255) ? 8'd255 : 8'(k)));
      push_release((k > 255) ? 8'd255 : 8'(k));
      pll_lock_i = 1'b0;
      @(negedge clock);
      pll_lock_i = 1'b1;
      wait_until(4, 20, "sat_loss", n);
      wait_until(2, 80, "sat_run", n);
    end
    check("loss_saturated", int'(lock_loss_count), 255);

    // Async reset mid-RELEASE
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd255));
    exp_q.push_back(snap(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd255));
    exp_q.push_back(snap(1'b0, 1'b1, 3'b110, 1'b0, 2'd0, 8'd255));
    exp_q.push_back(snap(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0));
    pll_lock_i = 1'b0;
    @(negedge clock);
    pll_lock_i = 1'b1;
    wait_until(5, 80, "release_110", n);
    #2;
    reset = 1'b1;
    #1;
    check("areset_pll_rst", int'(pll_rst_o), 1);
    check("areset_locked", int'(locked_o), 0);
    check("areset_rst_out", int'(rst_out), 7);
    check("areset_fault", int'(fault_o), 0);
    check("areset_retry", int'(retry_count), 0);
    check("areset_loss_count", int'(lock_loss_count), 0);
    repeat (3) @(negedge clock);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
